// File: rtl/pelican_perm_bits_inv.sv
// Pelican bit-permutation inverse (forward too when PELICAN_PERM_DIR_EN is defined), LANES words per cycle.
// Latency 4/LANES+1 cycles accept-to-out_valid; result held until out_ready, in_ready low while busy.
module pelican_perm_bits_inv #(
  parameter int LANES = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_b0,
  input  logic [31:0] in_b1,
  input  logic [31:0] in_b2,
  input  logic [31:0] in_b3,
`ifdef PELICAN_PERM_DIR_EN
  input  logic        dir,
`endif
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_a0,
  output logic [31:0] out_a1,
  output logic [31:0] out_a2,
  output logic [31:0] out_a3,
  output logic        busy
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]  r_state;
  logic [2:0]  r_cnt;
  logic [31:0] r_b [4];
  logic [31:0] r_a [4];
  logic        w_fwd;

  // Bit 4k+m of the recovered word sits at bit 8*((j-m) mod 4)+k of the permuted word.
  function automatic logic [31:0] f_perm(input logic [1:0] j, input logic [31:0] w, input logic fwd);
    logic [31:0] y;
    logic [4:0]  i_a;
    logic [4:0]  i_b;
    y = '0;
    for (int k = 0; k < 8; k++) begin
      for (int m = 0; m < 4; m++) begin
        i_a = {3'(k), 2'(m)};
        i_b = {j - 2'(m), 3'(k)};
        if (fwd) y[i_b] = w[i_a];
        else     y[i_a] = w[i_b];
      end
    end
    return y;
  endfunction

`ifdef PELICAN_PERM_DIR_EN
  logic r_dir;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_dir <= 1'b0;
    else if (r_state == S_IDLE && in_valid)
      r_dir <= dir;
  end
  assign w_fwd = r_dir;
`else
  assign w_fwd = 1'b0;
`endif

  // The counter carry into bit 2 marks all four words written; DONE follows one cycle later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      for (int i = 0; i < 4; i++) begin
        r_b[i] <= '0;
        r_a[i] <= '0;
      end
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_b[0]  <= in_b0;
            r_b[1]  <= in_b1;
            r_b[2]  <= in_b2;
            r_b[3]  <= in_b3;
            r_cnt   <= '0;
            r_state <= S_RUN;
          end
        end
        S_RUN: begin
          if (r_cnt[2]) begin
            r_state <= S_DONE;
          end else begin
            for (int l = 0; l < LANES; l++)
              r_a[r_cnt[1:0] + 2'(l)] <= f_perm(r_cnt[1:0] + 2'(l), r_b[r_cnt[1:0] + 2'(l)], w_fwd);
            r_cnt <= r_cnt + 3'(LANES);
          end
        end
        S_DONE: begin
          if (out_ready) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign in_ready  = (r_state == S_IDLE);
  assign out_valid = (r_state == S_DONE);
  assign busy      = (r_state == S_RUN) || (r_state == S_DONE);
  assign out_a0    = r_a[0];
  assign out_a1    = r_a[1];
  assign out_a2    = r_a[2];
  assign out_a3    = r_a[3];

endmodule

// File: tb/tb_pelican_perm_bits_inv.sv
// Bench for pelican_perm_bits_inv: LANES=1,2,4 instances, scoreboard queue of expected blocks.
module tb_pelican_perm_bits_inv;

  logic        clk;
  logic        rst_n;
  logic        in_valid  [3];
  logic        in_ready  [3];
  logic        out_valid [3];
  logic        out_ready [3];
  logic        busy      [3];
  logic [31:0] in_b      [3][4];
  logic [31:0] out_a     [3][4];
`ifdef PELICAN_PERM_DIR_EN
  logic        dir       [3];
`endif

  logic [127:0] exp_q [$];
  int n_chk;
  int n_pass;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    pelican_perm_bits_inv #(.LANES(1 << g)) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid[g]),
      .in_ready  (in_ready[g]),
      .in_b0     (in_b[g][0]),
      .in_b1     (in_b[g][1]),
      .in_b2     (in_b[g][2]),
      .in_b3     (in_b[g][3]),
`ifdef PELICAN_PERM_DIR_EN
      .dir       (dir[g]),
`endif
      .out_valid (out_valid[g]),
      .out_ready (out_ready[g]),
      .out_a0    (out_a[g][0]),
      .out_a1    (out_a[g][1]),
      .out_a2    (out_a[g][2]),
      .out_a3    (out_a[g][3]),
      .busy      (busy[g])
    );
  end

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h want %h", tag, got, exp);
  endtask

  // Model written from the source-bit side: source bit p = 8r+k lands at 4k+m with m = (j-r) mod 4.
  function automatic logic [127:0] m_inv(input logic [127:0] w);
    logic [127:0] y;
    int r, k, m;
    y = '0;
    for (int j = 0; j < 4; j++)
      for (int p = 0; p < 32; p++) begin
        r = p / 8;
        k = p % 8;
        m = (j - r + 4) % 4;
        y[7'(32*j + 4*k + m)] = w[7'(32*j + p)];
      end
    return y;
  endfunction

  function automatic logic [127:0] m_fwd(input logic [127:0] w);
    logic [127:0] y;
    int r, k, m;
    y = '0;
    for (int j = 0; j < 4; j++)
      for (int p = 0; p < 32; p++) begin
        k = p / 4;
        m = p % 4;
        r = (j - m + 4) % 4;
        y[7'(32*j + 8*r + k)] = w[7'(32*j + p)];
      end
    return y;
  endfunction

  function automatic logic [127:0] out_pack(input int g);
    return {out_a[g][3], out_a[g][2], out_a[g][1], out_a[g][0]};
  endfunction

  task automatic send(input int g, input logic [127:0] w, input logic d, input logic [127:0] e);
    int t;
    t = 0;
    while (!in_ready[g] && t < 40) begin
      @(negedge clk);
      t++;
    end
    for (int j = 0; j < 4; j++) in_b[g][j] = w[32*j +: 32];
`ifdef PELICAN_PERM_DIR_EN
    dir[g] = d;
`else
    if (d) $display("dir ignored in this build");
`endif
    in_valid[g] = 1'b1;
    @(negedge clk);
    in_valid[g] = 1'b0;
    exp_q.push_back(e);
  endtask

  task automatic recv(input int g, input string tag, input int hold, output logic [127:0] got);
    int lat;
    logic rdy_seen;
    logic [127:0] e;
    lat = 0;
    rdy_seen = 1'b0;
    while (!out_valid[g] && lat < 40) begin
      if (in_ready[g]) rdy_seen = 1'b1;
      @(negedge clk);
      lat++;
    end
    chk({tag, "_lat"}, 128'(lat), 128'(4 / (1 << g) + 1));
    chk({tag, "_rdy_busy"}, {126'd0, rdy_seen, in_ready[g]}, 128'd0);
    e = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
    for (int h = 0; h < hold; h++) begin
      in_valid[g] = h[0];
      for (int j = 0; j < 4; j++) in_b[g][j] = $urandom;
      @(negedge clk);
      chk({tag, "_hold_dat"}, out_pack(g), e);
      chk({tag, "_hold_ctl"}, {125'd0, out_valid[g], in_ready[g], busy[g]}, 128'b101);
    end
    in_valid[g] = 1'b0;
    got = out_pack(g);
    chk({tag, "_dat"}, got, e);
    out_ready[g] = 1'b1;
    @(negedge clk);
    out_ready[g] = 1'b0;
    chk({tag, "_idle"}, {126'd0, in_ready[g], out_valid[g]}, 128'b10);
  endtask

  initial begin
    logic [127:0] w;
    logic [127:0] got;
    logic [127:0] mid;
    logic stray;
    n_chk  = 0;
    n_pass = 0;
    rst_n  = 1'b0;
    for (int g = 0; g < 3; g++) begin
      in_valid[g]  = 1'b0;
      out_ready[g] = 1'b0;
`ifdef PELICAN_PERM_DIR_EN
      dir[g] = 1'b0;
`endif
      for (int j = 0; j < 4; j++) in_b[g][j] = '0;
    end
    repeat (2) @(negedge clk);
    for (int g = 0; g < 3; g++) begin
      chk("rst_ctl", {125'd0, in_ready[g], out_valid[g], busy[g]}, 128'b100);
      chk("rst_dat", out_pack(g), 128'd0);
    end
    rst_n = 1'b1;
    @(negedge clk);

    send(0, {96'd0, 32'h0000_0002}, 1'b0, {96'd0, 32'h0000_0010});
    recv(0, "bit_b0", 0, got);
    send(0, {64'd0, 32'h0000_0001, 32'd0}, 1'b0, {64'd0, 32'h0000_0002, 32'd0});
    recv(0, "bit_b1", 0, got);
    send(0, {32'h0100_0000, 96'd0}, 1'b0, {32'h0000_0001, 96'd0});
    recv(0, "bit_b3", 0, got);
    send(0, {32'd0, 32'h8000_0000, 64'd0}, 1'b0, {32'd0, 32'h8000_0000, 64'd0});
    recv(0, "bit_b2", 0, got);
    send(0, {128{1'b1}}, 1'b0, {128{1'b1}});
    recv(0, "ones", 0, got);

    w = {$urandom, $urandom, $urandom, $urandom};
    send(0, w, 1'b0, m_inv(w));
    recv(0, "bp", 10, got);

    for (int g = 0; g < 3; g++)
      for (int n = 0; n < 6; n++) begin
        w = {$urandom, $urandom, $urandom, $urandom};
        send(g, w, 1'b0, m_inv(w));
        recv(g, "rnd", 0, got);
      end

    send(0, {128{1'b1}}, 1'b0, {128{1'b1}});
    @(negedge clk);
    chk("mid_busy", {127'd0, busy[0]}, 128'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_ctl", {125'd0, in_ready[0], out_valid[0], busy[0]}, 128'b100);
    chk("mid_rst_dat", out_pack(0), 128'd0);
    if (exp_q.size() > 0) void'(exp_q.pop_front());
    @(negedge clk);
    rst_n = 1'b1;
    stray = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (out_valid[0]) stray = 1'b1;
    end
    chk("no_stray", {127'd0, stray}, 128'd0);

`ifdef PELICAN_PERM_DIR_EN
    for (int g = 0; g < 3; g++)
      for (int n = 0; n < 1000; n++) begin
        w = {$urandom, $urandom, $urandom, $urandom};
        send(g, w, 1'b1, m_fwd(w));
        recv(g, "fwd", 0, mid);
        send(g, mid, 1'b0, m_inv(mid));
        recv(g, "inv", 0, got);
        chk("round_trip", got, w);
      end
`else
    w = m_fwd({$urandom, $urandom, $urandom, $urandom});
    send(1, w, 1'b0, m_inv(w));
    recv(1, "fwd_model", 0, got);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
